// File: rtl/tetris_pkg.sv
// Key codes shared by the keyboard front end and the game sequencer.
package tetris_pkg;

  localparam int KEY_W = 3;

  localparam logic [KEY_W-1:0] KEY_NONE     = 3'd0;
  localparam logic [KEY_W-1:0] KEY_ESC      = 3'd1;
  localparam logic [KEY_W-1:0] KEY_SPACE    = 3'd2;
  localparam logic [KEY_W-1:0] KEY_CW       = 3'd3;
  localparam logic [KEY_W-1:0] KEY_CCW      = 3'd4;
  localparam logic [KEY_W-1:0] KEY_LEFT     = 3'd5;
  localparam logic [KEY_W-1:0] KEY_RIGHT    = 3'd6;
  localparam logic [KEY_W-1:0] KEY_RESERVED = 3'd7;

  // Only the horizontal moves auto-repeat while held.
  function automatic logic is_repeat_key(input logic [KEY_W-1:0] code);
    return (code == KEY_LEFT) || (code == KEY_RIGHT);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small circular event buffer with a flush that can load one entry in the same cycle.
module key_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = KEY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [W-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_rd;
  logic [AW:0]  r_wr;
  logic [AW:0]  w_count;
  logic         w_do_pop;
  logic         w_do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count   = r_wr - r_rd;
  assign full      = (w_count == (AW + 1)'(DEPTH));
  assign empty     = (w_count == '0);
  assign count     = w_count;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
    end else if (flush) begin
      // Flush wins over any pop; a simultaneous push becomes the only entry.
      r_rd <= '0;
      r_wr <= push ? (AW + 1)'(1) : '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush && push) begin
      r_mem[0] <= push_data;
    end else if (!flush && w_do_push) begin
      r_mem[r_wr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Converts the level key code from the keyboard decoder into press and auto-repeat
// events, queued in order for the game sequencer; escape flushes the queue.
module key_event_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_W-1:0]       key_code,
  output logic                   ev_valid,
  output logic [KEY_W-1:0]       ev_code,
  input  logic                   ev_ready,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow
);

  localparam logic [31:0] LP_FIRE   = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] LP_RELOAD = 32'(REPEAT_DELAY - REPEAT_RATE);

  logic [KEY_W-1:0] w_key_in;
  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_kc_s;
  logic [KEY_W-1:0] r_held_code;
  logic [31:0]      r_rpt_cnt;
  logic             r_overflow;

  logic             w_press;
  logic             w_holding;
  logic             w_rpt_fire;
  logic             w_event;
  logic [KEY_W-1:0] w_ev_code;
  logic             w_esc;
  logic             w_pop;
  logic             w_drop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;

  // The reserved code is folded to "no key" before it can reach any logic.
  assign w_key_in = (key_code == KEY_RESERVED) ? KEY_NONE : key_code;

  assign w_press    = (r_kc_s != KEY_NONE) && (r_kc_s != r_held_code);
  assign w_holding  = (r_kc_s == r_held_code) && is_repeat_key(r_kc_s);
  assign w_rpt_fire = w_holding && (r_rpt_cnt == LP_FIRE);
  assign w_event    = w_press || w_rpt_fire;
  assign w_ev_code  = w_press ? r_kc_s : r_held_code;
  assign w_esc      = w_press && (r_kc_s == KEY_ESC);

  // Handshake: the head entry transfers on any cycle where ev_valid && ev_ready;
  // ev_code holds steady while ev_valid is high and ev_ready is low.
  assign w_pop  = ev_valid && ev_ready;
  assign w_drop = w_event && !w_esc && w_full && !w_pop;
  assign w_push = w_event && !w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= KEY_NONE;
      r_kc_s      <= KEY_NONE;
      r_held_code <= KEY_NONE;
      r_rpt_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync1     <= w_key_in;
      r_kc_s      <= r_sync1;
      r_held_code <= r_kc_s;
      if (w_press) begin
        r_rpt_cnt <= '0;
      end else if (w_holding) begin
        r_rpt_cnt <= w_rpt_fire ? LP_RELOAD : r_rpt_cnt + 32'd1;
      end else begin
        r_rpt_cnt <= '0;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_ev_code),
    .pop       (w_pop),
    .flush     (w_esc),
    .count     (ev_count),
    .full      (w_full),
    .empty     (w_empty),
    .head      (ev_code)
  );

  assign ev_valid = !w_empty;
  assign overflow = r_overflow;

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits between the PS/2 Keyboard decoder and the game-logic sequencer.
- Turns the decoder's level-style 3-bit key code into discrete press events and adds auto-repeat for left/right.
- Buffers events in a small FIFO and hands them to the game logic over a valid/ready handshake.
- Replaces the per-key pressed_write/pressed_read counter pairs with one ordered, lossless-until-full event stream. Escape gets flush priority.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- REPEAT_DELAY, 50_000_000, clk cycles a left/right key must be held before the first repeat event.
- REPEAT_RATE, 10_000_000, clk cycles between subsequent repeat events while still held.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- key_code  in  3  raw code from the Keyboard decoder, asynchronous to the game logic. Codes: 0 none, 1 esc, 2 space, 3 cw, 4 ccw, 5 left, 6 right, 7 reserved.
- ev_valid  out  1  head-of-queue event available.
- ev_code  out  3  head-of-queue key code (1..6).
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; an event was dropped because the queue was full.

Behaviour:
- Single clock domain on clk; rst is synchronous and active-high.
- Reset values: ev_valid=0, ev_code=0, ev_count=0, overflow=0. Reset also clears the synchroniser, held-code register and repeat counter.
- Input sync: key_code passes through a 2-flop synchroniser giving kc_s. A register held_code stores last cycle's kc_s.
- Code 7 is treated as 0 everywhere.
- Press event: generated in the cycle kc_s != 0 and kc_s != held_code. This covers 0→k and also k→j with no release in between. Release (k→0) generates nothing.
- Latency: key_code change to ev_valid is 3 cycles when the queue is empty (2 sync + 1 enqueue).
- Auto-repeat, codes 5 and 6 only:
  - A 32-bit counter resets to 0 on every press event and counts while kc_s == held_code == 5 or 6.
  - When the counter reaches REPEAT_DELAY-1, one repeat event is generated and the counter reloads to REPEAT_DELAY-REPEAT_RATE.
  - From then on a repeat fires every REPEAT_RATE cycles.
  - Any other code, or 0, holds the counter at 0.
- Escape priority: a press event of code 1 flushes the FIFO (all entries discarded) and writes the single entry 1 in the same cycle. ev_count becomes 1. A simultaneous pop is ignored. overflow is not affected.
- FIFO: circular buffer with rd/wr pointers one bit wider than the index.
  - full = occupancy == DEPTH; empty = occupancy == 0.
  - Pop when ev_valid && ev_ready.
  - Push when an event exists and (!full or pop this cycle). Push and pop in the same cycle are both performed; occupancy is unchanged.
  - An event arriving while full with no pop is dropped and overflow is set to 1. overflow clears only on rst.
- Output: ev_valid = !empty and ev_code = mem[rd] (registered storage, combinational read). ev_code is stable while ev_valid && !ev_ready. ev_code = 0 when empty.
- At most one event is generated per cycle. A press and a repeat cannot coincide because a press resets the counter.
- Reset mid-operation: all state cleared next edge. Events in flight in the synchroniser are lost. A key still held after reset produces a fresh press once kc_s settles.

Decomposition:
- Shared package tetris_pkg:
  - Key code localparams KEY_NONE=0, KEY_ESC=1, KEY_SPACE=2, KEY_CW=3, KEY_CCW=4, KEY_LEFT=5, KEY_RIGHT=6.
  - Also used by the game sequencer.
- One sub-module, key_fifo:
  - Parameterised DEPTH and width 3.
  - Ports: push, push_data, pop, flush, count, full, empty, head.
- Edge detect, repeat counter and escape arbitration stay in key_event_queue.

Test Plan:
- Single press, empty queue: key_code 0→3 held 10 cycles then 0, ev_ready=0 → ev_valid=1 with ev_code=3 three cycles after the change, ev_count=1; no further events.
- Auto-repeat, REPEAT_DELAY=20, REPEAT_RATE=5, ev_ready=1: hold key 5 for 40 cycles → exactly 5 events of code 5. They appear at the press, then after 20, 25, 30 and 35 held cycles.
- Key change without release: 5→6 directly → two events, 5 then 6. The repeat counter restarts on 6.
- Full plus drop, DEPTH=4, ev_ready=0: presses 2,3,4,2 then 6 → ev_count=4, overflow=1, queue holds 2,3,4,2. Drain with ev_ready=1 → outputs in that order, then ev_valid=0. overflow stays 1.
- Full with simultaneous pop: queue full, ev_ready=1 in the same cycle a press of 4 arrives → ev_count stays 4, 4 is last out, overflow=0.
- Escape flush: queue holds 3,4,5 and esc is pressed → ev_count=1, ev_code=1. rst asserted mid-hold of key 6 → all outputs 0 next cycle. With key 6 still held, a new event 6 appears 3 cycles after rst deasserts.
